pe_mac_sequencer: RTL

//  Cycle-accurate control sequencer for one SV_PE MAC datapath (2-stage multiplier, 2-deep accumulator).
//  Per window: accepts KERNEL_SIZE operand pairs (ifmap x filter), then merges one incoming psum.

---
 rtl/pe_mac_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pe_mac_sequencer.sv
// ---------------------------------------------------------------------------
// pe_mac_sequencer
//
// Control sequencer for one PE MAC datapath (pipelined multiplier feeding a
// pipelined accumulator). For each window it accepts KERNEL_SIZE operand
// pairs, then merges one upstream psum. Once the datapath has drained, it
// flags the finished window sum. This repeats for num_windows windows.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   start            1-cycle run request, accepted from IDLE only
//   num_windows      windows in the run, sampled with start
//   op_valid/ready   operand pair handshake (ready only in LOAD)
//   psum_in_valid/   upstream psum handshake (ready only in PSUM)
//   psum_in_ready
//   mult_sel         1: accumulator adds product, 0: adds psum input
//   add_en           1: selected operand enters accumulator, 0: bubble
//   acc_clr          restart accumulation (first add of a window)
//   psum_out_valid   1-cycle pulse, window sum available at PE output
//   busy             run in progress (LOAD/PSUM/DRAIN)
//   done             1-cycle pulse at run completion
//   win_cnt          windows completed in the current run
//
// FSM states
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start
//   S_LOAD  | accepting operand pairs, one tap per op_valid cycle
//   S_PSUM  | waiting for the upstream psum
//   S_DRAIN | letting the multiplier/accumulator pipelines empty
//   S_DONE  | one-cycle done pulse, then back to idle
// ---------------------------------------------------------------------------
module pe_mac_sequencer #(
  parameter int KERNEL_SIZE = 3,
  parameter int MULT_LAT    = 2,
  parameter int ACC_DEPTH   = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] num_windows,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             psum_in_valid,
  output logic             psum_in_ready,
  output logic             mult_sel,
  output logic             add_en,
  output logic             acc_clr,
  output logic             psum_out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] win_cnt
);

  localparam int TAP_W     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int DRAIN_CYC = MULT_LAT + ACC_DEPTH;
  localparam int DRN_W     = $clog2(DRAIN_CYC + 1);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KERNEL_SIZE - 1);
  // The timer counts down to zero; the zero cycle is the output pulse, so
  // loading DRAIN_CYC-1 puts the pulse DRAIN_CYC cycles after the psum cycle.
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PSUM,
    S_DRAIN,
    S_DONE
  } state_t;

  // One control slot per cycle travels down the multiplier-latency pipe.
  // An all-zero slot means nothing was issued that cycle.
  typedef struct packed {
    logic sel;
    logic add;
    logic clr;
  } slot_t;

  state_t                      state_q,   state_d;
  logic   [TAP_W-1:0]          tap_cnt_q, tap_cnt_d;
  logic   [DRN_W-1:0]          drain_q,   drain_d;
  logic   [CNT_W-1:0]          win_cnt_q, win_cnt_d;
  logic   [CNT_W-1:0]          num_win_q, num_win_d;
  slot_t  [MULT_LAT-1:0]       pipe_q,    pipe_d;

  slot_t                       slot_in;
  logic   [CNT_W:0]            win_next;
  logic                        drain_tc;

  assign win_next = {1'b0, win_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign drain_tc = (drain_q == '0);

  // -------------------------------------------------------------------------
  // Next-state and counters
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    drain_d   = drain_q;
    win_cnt_d = win_cnt_q;
    num_win_d = num_win_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_win_d = num_windows;
          win_cnt_d = '0;
          tap_cnt_d = '0;
          state_d   = (num_windows == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        // op_ready is high throughout LOAD, so op_valid is the handshake.
        if (op_valid) begin
          if (tap_cnt_q == TAP_LAST) begin
            tap_cnt_d = '0;
            state_d   = S_PSUM;
          end else begin
            tap_cnt_d = tap_cnt_q + 1'b1;
          end
        end
      end

      S_PSUM: begin
        if (psum_in_valid) begin
          drain_d = DRN_LOAD;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (drain_tc) begin
          win_cnt_d = win_cnt_q + 1'b1;
          state_d   = (win_next < {1'b0, num_win_q}) ? S_LOAD : S_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control slot issue and alignment pipe
  // Tap slots ride the pipe for MULT_LAT cycles so they meet their product.
  // The psum slot enters the same pipe the cycle the psum is consumed; since
  // that is always after the last tap, it comes out behind the last product.
  // A LOAD cycle without op_valid issues a bubble (sel=1, add=0).
  // -------------------------------------------------------------------------
  always_comb begin
    slot_in = '0;
    if (state_q == S_LOAD) begin
      slot_in.sel = 1'b1;
      slot_in.add = op_valid;
      // First accepted tap of the window restarts the accumulator; stalls
      // before it only produce bubbles, so the clear lands on the first add.
      slot_in.clr = op_valid && (tap_cnt_q == '0);
    end else if ((state_q == S_PSUM) && psum_in_valid) begin
      slot_in.sel = 1'b0;
      slot_in.add = 1'b1;
      slot_in.clr = 1'b0;
    end
  end

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = slot_in;
    for (int i = 1; i < MULT_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      tap_cnt_q <= '0;
      drain_q   <= '0;
      win_cnt_q <= '0;
      num_win_q <= '0;
      pipe_q    <= '0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      drain_q   <= drain_d;
      win_cnt_q <= win_cnt_d;
      num_win_q <= num_win_d;
      pipe_q    <= pipe_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // -------------------------------------------------------------------------
  assign op_ready       = (state_q == S_LOAD);
  assign psum_in_ready  = (state_q == S_PSUM);
  assign busy           = (state_q == S_LOAD) || (state_q == S_PSUM) ||
                          (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign psum_out_valid = (state_q == S_DRAIN) && drain_tc;
  assign win_cnt        = win_cnt_q;

  assign mult_sel       = pipe_q[MULT_LAT-1].sel;
  assign add_en         = pipe_q[MULT_LAT-1].add;
  assign acc_clr        = pipe_q[MULT_LAT-1].clr;

endmodule
